// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and digit type for the BCD adder
//
// Purpose: single home for BCD digit width, the largest legal digit value
// and the decimal correction constant, plus the 4-bit digit typedef.
// Ports: none (package).
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_CORR    = 4'd6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder
//
// Purpose: adds two BCD digits and a carry, applies decimal correction.
// Ports:
//   a_i, b_i  : input digits (may be illegal 10..15; still processed)
//   cin_i     : carry into this digit
//   digit_o   : corrected sum digit
//   cout_o    : decimal carry out of this digit
//   err_o     : set when either input digit exceeds 9
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       cin_i,
  output bcd_digit_t digit_o,
  output logic       cout_o,
  output logic       err_o
);

  // 5 bits holds the worst case 15 + 15 + 1 = 31 without overflow.
  logic [BCD_DIGIT_W:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {1'b0, b_i} + {{BCD_DIGIT_W{1'b0}}, cin_i};

  always_comb begin
    digit_o = raw_sum[BCD_DIGIT_W-1:0];
    cout_o  = 1'b0;
    if (raw_sum > {1'b0, BCD_MAX}) begin
      // Adding 6 skips the six unused binary codes; the 4-bit wrap
      // discards the binary carry, which is replaced by the decimal one.
      digit_o = raw_sum[BCD_DIGIT_W-1:0] + BCD_CORR;
      cout_o  = 1'b1;
    end
  end

  assign err_o = (a_i > BCD_MAX) || (b_i > BCD_MAX);

endmodule

// File: rtl/bcd_adder.sv
// rtl/bcd_adder.sv - registered carry-rippled multi-digit BCD adder
//
// Purpose: adds two NDIGITS-digit packed BCD operands plus carry-in and
// registers sum, decimal carry-out and an invalid-digit flag, one cycle
// after sampling.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : operands valid this cycle
//   a, b       : packed BCD operands, digit 0 in bits [3:0]
//   cin        : decimal carry into digit 0
//   sum        : registered BCD sum (held when in_valid is low)
//   cout       : registered carry out of the top digit
//   err        : registered flag, some input digit exceeded 9
//   out_valid  : registered, sum/cout/err carry a new result
module bcd_adder
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] b,
  input  logic                           cin,
  output logic [BCD_DIGIT_W*NDIGITS-1:0] sum,
  output logic                           cout,
  output logic                           err,
  output logic                           out_valid
);

  logic [NDIGITS:0]                 carry;
  logic [NDIGITS-1:0]               dig_err;
  logic [BCD_DIGIT_W*NDIGITS-1:0]   sum_d;
  logic                             cout_d;
  logic                             err_d;

  logic [BCD_DIGIT_W*NDIGITS-1:0]   sum_q;
  logic                             cout_q;
  logic                             err_q;
  logic                             out_valid_q;

  assign carry[0] = cin;

  // Carry ripples through every digit within the single cycle.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    bcd_digit_add u_digit (
      .a_i     (a[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .b_i     (b[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cin_i   (carry[i]),
      .digit_o (sum_d[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cout_o  (carry[i+1]),
      .err_o   (dig_err[i])
    );
  end

  assign cout_d = carry[NDIGITS];
  assign err_d  = |dig_err;

  // Result registers only load on a valid sample so they hold across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        err_q  <= err_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_adder.sv
// tb/tb_bcd_adder.sv - self-checking bench for bcd_adder (1- and 2-digit)
module tb_bcd_adder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       v1 = 1'b0, c1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic [3:0] s1;
  logic       co1, e1, ov1;

  logic       v2 = 1'b0, c2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic [7:0] s2;
  logic       co2, e2, ov2;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  bcd_adder #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .err(e1), .out_valid(ov1)
  );

  bcd_adder #(.NDIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .cin(c2),
    .sum(s2), .cout(co2), .err(e2), .out_valid(ov2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {err, cout, sum[31:0]}. Legal operands use plain decimal
  // arithmetic; operands with illegal digits fall back to the digit rule.
  function automatic logic [33:0] bcd_model(input int n, input logic [31:0] a,
                                             input logic [31:0] b, input logic ci);
    bit          bad = 1'b0;
    longint      ta = 0, tb = 0, tot, lim = 1;
    logic [31:0] s = '0;
    logic        co;
    int          c, t;
    for (int i = 0; i < n; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    if (!bad) begin
      for (int i = n - 1; i >= 0; i--) begin
        ta  = ta * 10 + longint'(a[4*i +: 4]);
        tb  = tb * 10 + longint'(b[4*i +: 4]);
        lim = lim * 10;
      end
      tot = ta + tb + longint'(ci);
      co  = (tot >= lim);
      tot = tot % lim;
      for (int i = 0; i < n; i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = int'(ci);
      for (int i = 0; i < n; i++) begin
        t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
        if (t > 9) begin
          s[4*i +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          c = 0;
        end
      end
      co = (c != 0);
    end
    return {bad, co, s};
  endfunction

  // Expected outputs after each edge.
  logic        m1_valid = 1'b0, m2_valid = 1'b0;
  logic [33:0] m1_res = '0, m2_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_valid = 1'b0; m1_res = '0;
      m2_valid = 1'b0; m2_res = '0;
    end else begin
      m1_valid = v1;
      if (v1) m1_res = bcd_model(1, 32'(a1), 32'(b1), c1);
      m2_valid = v2;
      if (v2) m2_res = bcd_model(2, 32'(a2), 32'(b2), c2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp1 out_valid", 32'(ov1), 32'(m1_valid));
      chk("cmp1 sum",       32'(s1),  m1_res[31:0]);
      chk("cmp1 cout",      32'(co1), 32'(m1_res[32]));
      chk("cmp1 err",       32'(e1),  32'(m1_res[33]));
      chk("cmp2 out_valid", 32'(ov2), 32'(m2_valid));
      chk("cmp2 sum",       32'(s2),  m2_res[31:0]);
      chk("cmp2 cout",      32'(co2), 32'(m2_res[32]));
      chk("cmp2 err",       32'(e2),  32'(m2_res[33]));
    end
  end

  // Called at a negedge; samples at the next posedge, checks at the negedge after.
  task automatic vec1(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] es, input logic ec, input logic ee);
    a1 = a; b1 = b; c1 = ci; v1 = 1'b1;
    @(negedge clk);
    chk("vec1 out_valid", 32'(ov1), 32'd1);
    chk("vec1 sum",       32'(s1),  32'(es));
    chk("vec1 cout",      32'(co1), 32'(ec));
    chk("vec1 err",       32'(e1),  32'(ee));
  endtask

  task automatic vec2(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec);
    a2 = a; b2 = b; c2 = ci; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    chk("vec2 out_valid", 32'(ov2), 32'd1);
    chk("vec2 sum",       32'(s2),  32'(es));
    chk("vec2 cout",      32'(co2), 32'(ec));
    chk("vec2 err",       32'(e2),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 32'(ov1), 32'd0);
    chk("reset sum",       32'(s1),  32'd0);
    chk("reset cout",      32'(co1), 32'd0);
    chk("reset err",       32'(e1),  32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single-digit directed vectors, back to back.
    vec1(4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b0);
    vec1(4'd4, 4'd6, 1'b0, 4'd0, 1'b1, 1'b0);
    vec1(4'd9, 4'd9, 1'b0, 4'd8, 1'b1, 1'b0);
    vec1(4'd2, 4'd7, 1'b1, 4'd0, 1'b1, 1'b0);
    vec1(4'd0, 4'd9, 1'b1, 4'd0, 1'b1, 1'b0);

    // Illegal digit, then a legal vector clears err.
    vec1(4'hA, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
    vec1(4'hF, 4'hF, 1'b1, 4'h5, 1'b1, 1'b1);
    vec1(4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);

    // Valid gating: 1,0,1 with the sum held across the gap.
    vec1(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
    a1 = 4'd7; b1 = 4'd1; v1 = 1'b0;
    @(negedge clk);
    chk("gap out_valid", 32'(ov1), 32'd0);
    chk("gap sum held",  32'(s1),  32'd3);
    vec1(4'd4, 4'd4, 1'b0, 4'd8, 1'b0, 1'b0);
    v1 = 1'b0;

    // Two-digit vectors.
    vec2(8'h99, 8'h01, 1'b0, 8'h00, 1'b1);
    vec2(8'h45, 8'h37, 1'b1, 8'h83, 1'b0);
    vec2(8'h99, 8'h99, 1'b1, 8'h99, 1'b1);
    vec2(8'h50, 8'h49, 1'b0, 8'h99, 1'b0);

    // Asynchronous reset between edges while out_valid is high.
    vec1(4'd6, 4'd2, 1'b0, 4'd8, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(ov1), 32'd0);
    chk("async rst sum",       32'(s1),  32'd0);
    chk("async rst cout",      32'(co1), 32'd0);
    chk("async rst sum2",      32'(s2),  32'd0);
    chk("async rst cout2",     32'(co2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec1(4'd5, 4'd5, 1'b1, 4'd1, 1'b1, 1'b0);

    // Exhaustive legal single-digit sweep.
    for (int x = 0; x <= 9; x++)
      for (int y = 0; y <= 9; y++)
        for (int c = 0; c <= 1; c++) begin
          a1 = 4'(x); b1 = 4'(y); c1 = (c != 0); v1 = 1'b1;
          @(negedge clk);
          chk("exh value", 32'(int'(s1) + 10 * int'(co1)), 32'(x + y + c));
          chk("exh err",   32'(e1), 32'd0);
        end
    v1 = 1'b0;
    @(negedge clk);
    chk("final out_valid", 32'(ov1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
